// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result buffer: opcode encoding, entry
// layout and the carry-masking rule applied at write time.
package alu_pkg;

  // ALU opcode encoding as produced by the combinational ALU.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_XRB = 2'b11
  } alu_op_e;

  // Extra bits stored beside the result: opcode(2) + zero(1) + carry(1).
  localparam int unsigned FLAG_W = 4;

  // Entry packing order, MSB to LSB: {opcode, zero, carry, data}.
  function automatic int unsigned entry_width(input int unsigned width);
    return width + FLAG_W;
  endfunction

  // Carry is only meaningful for arithmetic opcodes that are not pass-through.
  function automatic logic carry_kept(input logic [1:0] op, input logic pass);
    return !pass && ((op == OP_ADD) || (op == OP_SUB));
  endfunction

  // Pass-through results are tagged as OP_AND; the pass flag itself is dropped.
  function automatic logic [1:0] stored_opcode(input logic [1:0] op, input logic pass);
    return pass ? OP_AND : op;
  endfunction

endpackage

// File: rtl/alu_result_fifo_mem.sv
// Entry storage: DEPTH x ENTRY_W registers, synchronous write, combinational read.
module fifo_mem #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 8,
  parameter int unsigned AW      = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write port: storage is never reset, empty outputs are masked upstream.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO behind the 4-bit ALU: stores result, masked carry, zero
// flag and opcode per entry, with valid/ready on both sides and a saturating
// counter of cycles in which the producer was stalled.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_out,
  input  logic                       in_cout,
  input  logic [1:0]                 in_opcode,
  input  logic                       in_pass,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic [1:0]                 out_opcode,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = entry_width(WIDTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        occ;
  logic [CNT_W-1:0]   stalls;
  logic               push;
  logic               pop;
  logic               stall;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic               wr_carry;
  logic               wr_zero;
  logic [1:0]         wr_opcode;

  assign in_ready  = !rst && (occ != FULL);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign stall     = in_valid && !in_ready;

  // Flags are derived once at write time and stored with the result.
  always_comb begin
    wr_carry  = carry_kept(in_opcode, in_pass) ? in_cout : 1'b0;
    wr_zero   = (in_out == '0);
    wr_opcode = stored_opcode(in_opcode, in_pass);
    wr_entry  = {wr_opcode, wr_zero, wr_carry, in_out};
  end

  fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .AW      (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: unchanged on simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Saturating count of producer cycles refused by a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stalls <= '0;
    end else if (stall && (stalls != '1)) begin
      stalls <= stalls + 1'b1;
    end
  end

  // Head entry is shown ahead; all fields read as zero while empty.
  always_comb begin
    out_data   = '0;
    out_carry  = 1'b0;
    out_zero   = 1'b0;
    out_opcode = '0;
    if (out_valid) begin
      out_data   = rd_entry[WIDTH-1:0];
      out_carry  = rd_entry[WIDTH];
      out_zero   = rd_entry[WIDTH+1];
      out_opcode = rd_entry[WIDTH+3:WIDTH+2];
    end
  end

  assign count     = occ;
  assign stall_cnt = stalls;

endmodule
